// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder.
//   state_t          : responder FSM states
//   IO_ADDR_DEFAULT  : default address of the memory-mapped I/O word
//   OOR_RDATA        : data returned for an out-of-range read
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
    localparam logic [15:0] OOR_RDATA       = 16'h0000;

endpackage

// File: rtl/mem_responder_ram_sp.sv
// Single-port synchronous RAM, 2^ADDR_W words of DATA_W bits.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset; blocks any write in its cycle
//   i_we    : write enable
//   i_addr  : word address (read and write)
//   i_wdata : write data
//   o_rdata : registered read data, one cycle after i_addr is presented
// The array itself is never cleared.
module ram_sp #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we && !i_rst) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the 16-bit CPU datapath. Services load/store
// requests from on-chip RAM and one memory-mapped I/O word, after a fixed
// number of wait states, and signals completion with a one-cycle Ready.
//   Clk      : system clock
//   Reset    : synchronous active-high reset
//   Req      : request strobe, held by the CPU until Ready
//   WE       : 1 = write, 0 = read (sampled with Req)
//   Addr     : word address (sampled with Req)
//   Wdata    : write data (sampled with Req)
//   Switches : switch word returned by reads of IO_ADDR
//   Rdata    : registered read data, valid with Ready and then held
//   Ready    : one-cycle completion pulse
//   Hex_Out  : hex display word, written by stores to IO_ADDR
//   Err      : sticky out-of-range access flag
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        WE,
    input  logic [15:0] Addr,
    input  logic [15:0] Wdata,
    input  logic [15:0] Switches,
    output logic [15:0] Rdata,
    output logic        Ready,
    output logic [15:0] Hex_Out,
    output logic        Err
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_range
        $error("mem_responder: WAIT_STATES must be within 0..15");
    end

    localparam logic [3:0] WS_L = WAIT_STATES[3:0];

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_we;
    logic [15:0] r_rdata;
    logic        r_ready;
    logic [15:0] r_hex;
    logic        r_err;

    logic              w_is_io;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_we;
    logic [15:0]       w_ram_rdata;

    assign w_is_io    = (r_addr == IO_ADDR);
    assign w_in_range = !w_is_io && ((r_addr >> ADDR_W) == 16'd0);

    // The RAM read is registered, so the address must be on the RAM port in
    // the cycle before ACCESS. With zero wait states that cycle is IDLE, when
    // the request has not been latched yet, hence the bypass to Addr.
    assign w_ram_addr = (r_state == IDLE) ? Addr[ADDR_W-1:0] : r_addr[ADDR_W-1:0];
    assign w_ram_we   = (r_state == ACCESS) && r_we && w_in_range;

    ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (16)
    ) u_ram (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 16'd0;
            r_wdata <= 16'd0;
            r_we    <= 1'b0;
            r_rdata <= 16'd0;
            r_ready <= 1'b0;
            r_hex   <= 16'd0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Req) begin
                        r_addr  <= Addr;
                        r_we    <= WE;
                        r_wdata <= Wdata;
                        r_cnt   <= WS_L;
                        r_state <= (WS_L != 4'd0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!r_we) begin
                        if (w_is_io) begin
                            r_rdata <= Switches;
                        end else if (w_in_range) begin
                            r_rdata <= w_ram_rdata;
                        end else begin
                            r_rdata <= OOR_RDATA;
                        end
                    end else if (w_is_io) begin
                        r_hex <= r_wdata;
                    end
                    if (!w_is_io && !w_in_range) begin
                        r_err <= 1'b1;
                    end
                    // Registered so that Ready is high exactly during DONE.
                    r_ready <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Rdata   = r_rdata;
    assign Ready   = r_ready;
    assign Hex_Out = r_hex;
    assign Err     = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Two instances: one with two wait
// states (sel 0) and one with zero wait states (sel 1). Directed scenarios
// are followed by randomized transactions checked against a transaction-level
// model of memory, I/O word, read data and the sticky error flag.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req2, req0;
    logic        we;
    logic [15:0] addr, wdata, sw;
    logic [15:0] rd2, hx2, rd0, hx0;
    logic        rdy2, er2, rdy0, er0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .WAIT_STATES(2), .IO_ADDR(16'hFFFF)) dut2 (
        .Clk(clk), .Reset(rst), .Req(req2), .WE(we), .Addr(addr), .Wdata(wdata),
        .Switches(sw), .Rdata(rd2), .Ready(rdy2), .Hex_Out(hx2), .Err(er2)
    );

    mem_responder #(.ADDR_W(8), .WAIT_STATES(0), .IO_ADDR(16'hFFFF)) dut0 (
        .Clk(clk), .Reset(rst), .Req(req0), .WE(we), .Addr(addr), .Wdata(wdata),
        .Switches(sw), .Rdata(rd0), .Ready(rdy0), .Hex_Out(hx0), .Err(er0)
    );

    // Issues one transaction to the selected instance and reports the cycle
    // in which Ready was seen (cycle 0 = cycle in which Req is sampled), plus
    // the outputs during that Ready cycle. lat = -1 means no Ready in budget.
    // With chg set, Addr/WE/Wdata are disturbed in cycle 1.
    task automatic do_txn(input bit sel, input bit we_i, input logic [15:0] a,
                          input logic [15:0] d, input bit chg, input logic [15:0] a2,
                          output int lat, output logic [15:0] rd,
                          output logic [15:0] hx, output logic er);
        @(negedge clk);
        we = we_i; addr = a; wdata = d;
        if (sel) req0 = 1'b1; else req2 = 1'b1;
        lat = -1; rd = 16'hxxxx; hx = 16'hxxxx; er = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1 && chg) begin
                addr = a2; we = ~we_i; wdata = ~d;
            end
            if ((sel ? rdy0 : rdy2) === 1'b1) begin
                lat = k;
                rd  = sel ? rd0 : rd2;
                hx  = sel ? hx0 : hx2;
                er  = sel ? er0 : er2;
                break;
            end
        end
        req0 = 1'b0; req2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req2 = 0; req0 = 0; we = 0; addr = 0; wdata = 0; sw = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({rd2, rdy2, hx2, er2} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_ws2: got rd=%h rdy=%b hex=%h err=%b, want all zero", rd2, rdy2, hx2, er2);
        end
        n_vec++;
        if ({rd0, rdy0, hx0, er0} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_ws0: got rd=%h rdy=%b hex=%h err=%b, want all zero", rd0, rdy0, hx0, er0);
        end
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] rd, hx; logic er;
        do_txn(0, 1, 16'h0012, 16'hBEEF, 0, 0, lat, rd, hx, er);
        n_vec++;
        if (lat !== 4) begin n_err++; $display("FAIL wr_latency: got %0d want 4", lat); end
        @(negedge clk);
        n_vec++;
        if (rdy2 !== 1'b0) begin n_err++; $display("FAIL ready_one_cycle: got %b want 0", rdy2); end
        do_txn(0, 0, 16'h0012, 16'h0000, 0, 0, lat, rd, hx, er);
        n_vec++;
        if (lat !== 4) begin n_err++; $display("FAIL rd_latency: got %0d want 4", lat); end
        n_vec++;
        if (rd !== 16'hBEEF) begin n_err++; $display("FAIL rd_data: got %h want beef", rd); end
        n_vec++;
        if (er !== 1'b0) begin n_err++; $display("FAIL rd_err: got %b want 0", er); end
    endtask

    task automatic test_io();
        int lat; logic [15:0] rd, hx; logic er;
        sw = 16'h1234;
        do_txn(0, 0, 16'hFFFF, 16'h0000, 0, 0, lat, rd, hx, er);
        n_vec++;
        if (rd !== 16'h1234) begin n_err++; $display("FAIL io_read: got %h want 1234", rd); end
        n_vec++;
        if (hx !== 16'h0000) begin n_err++; $display("FAIL io_hex_before: got %h want 0000", hx); end
        do_txn(0, 1, 16'hFFFF, 16'h00A5, 0, 0, lat, rd, hx, er);
        n_vec++;
        if (hx !== 16'h00A5) begin n_err++; $display("FAIL io_hex: got %h want 00a5", hx); end
        n_vec++;
        if (rd !== 16'h1234) begin n_err++; $display("FAIL io_rdata_held: got %h want 1234", rd); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [15:0] rd, hx; logic er;
        do_txn(0, 1, 16'h0000, 16'h7777, 0, 0, lat, rd, hx, er);
        do_txn(0, 1, 16'h0100, 16'h5A5A, 0, 0, lat, rd, hx, er);
        n_vec++;
        if (lat !== 4) begin n_err++; $display("FAIL oor_wr_ready: got %0d want 4", lat); end
        n_vec++;
        if (er !== 1'b1) begin n_err++; $display("FAIL oor_wr_err: got %b want 1", er); end
        n_vec++;
        if (rd !== 16'h1234) begin n_err++; $display("FAIL oor_wr_rdata: got %h want 1234", rd); end
        do_txn(0, 0, 16'h0100, 16'h0000, 0, 0, lat, rd, hx, er);
        n_vec++;
        if (lat !== 4 || rd !== 16'h0000) begin
            n_err++; $display("FAIL oor_rd: got lat=%0d rd=%h want lat=4 rd=0000", lat, rd);
        end
        do_txn(0, 0, 16'h0000, 16'h0000, 0, 0, lat, rd, hx, er);
        n_vec++;
        if (rd !== 16'h7777 || er !== 1'b1) begin
            n_err++; $display("FAIL oor_sticky: got rd=%h err=%b want rd=7777 err=1", rd, er);
        end
    endtask

    task automatic test_reset_mid_wait();
        int lat; logic [15:0] rd, hx; logic er;
        bit seen;
        do_txn(0, 1, 16'h0003, 16'h1111, 0, 0, lat, rd, hx, er);
        @(negedge clk);
        we = 1'b1; addr = 16'h0003; wdata = 16'hCAFE; req2 = 1'b1;
        @(negedge clk);
        rst = 1'b1; req2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({rd2, hx2, er2} !== 33'd0) begin
            n_err++; $display("FAIL rst_wait_state: got rd=%h hex=%h err=%b want zeros", rd2, hx2, er2);
        end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rdy2 !== 1'b0) seen = 1;
        end
        n_vec++;
        if (seen) begin n_err++; $display("FAIL rst_wait_ready: got pulse want none"); end
        do_txn(0, 0, 16'h0003, 16'h0000, 0, 0, lat, rd, hx, er);
        n_vec++;
        if (rd !== 16'h1111) begin n_err++; $display("FAIL rst_wait_nocommit: got %h want 1111", rd); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] rd, hx; logic er;
        int r1, r2;
        logic [15:0] d1, d2;
        do_txn(1, 1, 16'h0001, 16'hAAAA, 0, 0, lat, rd, hx, er);
        n_vec++;
        if (lat !== 2) begin n_err++; $display("FAIL ws0_latency: got %0d want 2", lat); end
        do_txn(1, 1, 16'h0002, 16'h5555, 0, 0, lat, rd, hx, er);
        @(negedge clk);
        we = 1'b0; addr = 16'h0001; req0 = 1'b1;
        r1 = -1; r2 = -1; d1 = 16'hxxxx; d2 = 16'hxxxx;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rdy0 === 1'b1) begin
                if (r1 < 0) begin
                    r1 = k; d1 = rd0; addr = 16'h0002;
                end else begin
                    r2 = k; d2 = rd0; break;
                end
            end
        end
        req0 = 1'b0;
        n_vec++;
        if (r1 !== 2 || d1 !== 16'hAAAA) begin
            n_err++; $display("FAIL b2b_first: got cycle=%0d rd=%h want cycle=2 rd=aaaa", r1, d1);
        end
        n_vec++;
        if (r2 !== 5 || d2 !== 16'h5555) begin
            n_err++; $display("FAIL b2b_second: got cycle=%0d rd=%h want cycle=5 rd=5555", r2, d2);
        end
    endtask

    task automatic test_busy_ignored();
        int lat; logic [15:0] rd, hx; logic er;
        do_txn(0, 1, 16'h0001, 16'hAAAA, 0, 0, lat, rd, hx, er);
        do_txn(0, 1, 16'h0002, 16'h5555, 0, 0, lat, rd, hx, er);
        do_txn(0, 0, 16'h0001, 16'h0000, 1, 16'h0002, lat, rd, hx, er);
        n_vec++;
        if (rd !== 16'hAAAA) begin n_err++; $display("FAIL busy_ignored: got %h want aaaa", rd); end
        do_txn(0, 0, 16'h0002, 16'h0000, 0, 0, lat, rd, hx, er);
        n_vec++;
        if (rd !== 16'h5555) begin n_err++; $display("FAIL busy_no_write: got %h want 5555", rd); end
    endtask

    task automatic test_random();
        logic [15:0] mm [2][256];
        bit          mv [2][256];
        logic [15:0] e_rd [2];
        logic [15:0] e_hx [2];
        logic        e_er [2];
        int lat; logic [15:0] rd, hx; logic er;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            e_rd[s] = 16'h0; e_hx[s] = 16'h0; e_er[s] = 1'b0;
            for (int w = 0; w < 256; w++) mv[s][w] = 0;
        end
        for (int i = 0; i < 60; i++) begin
            bit sel; bit w_i; int kind; logic [15:0] a, d;
            sel  = i[0];
            kind = $urandom_range(0, 9);
            w_i  = $urandom_range(0, 1) == 1;
            d    = 16'($urandom);
            sw   = 16'($urandom);
            if (kind == 0)      a = 16'hFFFF;
            else if (kind == 1) a = 16'($urandom_range(16'h0100, 16'hFFFE));
            else                a = 16'($urandom_range(0, 255));
            if (kind >= 2 && !w_i && !mv[sel][a[7:0]]) w_i = 1;
            do_txn(sel, w_i, a, d, 0, 0, lat, rd, hx, er);
            if (kind == 0) begin
                if (w_i) e_hx[sel] = d; else e_rd[sel] = sw;
            end else if (kind == 1) begin
                e_er[sel] = 1'b1;
                if (!w_i) e_rd[sel] = 16'h0000;
            end else begin
                if (w_i) begin mm[sel][a[7:0]] = d; mv[sel][a[7:0]] = 1; end
                else e_rd[sel] = mm[sel][a[7:0]];
            end
            n_vec++;
            if (lat !== (sel ? 2 : 4)) begin
                n_err++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, sel ? 2 : 4);
            end
            n_vec++;
            if (rd !== e_rd[sel]) begin
                n_err++; $display("FAIL rnd_rdata[%0d] addr=%h we=%b: got %h want %h", i, a, w_i, rd, e_rd[sel]);
            end
            n_vec++;
            if (hx !== e_hx[sel]) begin
                n_err++; $display("FAIL rnd_hex[%0d]: got %h want %h", i, hx, e_hx[sel]);
            end
            n_vec++;
            if (er !== e_er[sel]) begin
                n_err++; $display("FAIL rnd_err[%0d]: got %b want %b", i, er, e_er[sel]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_io();
        test_out_of_range();
        test_reset_mid_wait();
        test_back_to_back();
        test_busy_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the 16-bit CPU datapath.
- The CPU issues load/store requests from its address and data registers; this block services them from an on-chip word memory and a memory-mapped I/O word.
- It models SRAM wait states with a fixed, parameterised latency and returns read data plus a one-cycle Ready pulse, which the CPU uses to load its data register.

Parameters:
- ADDR_W, 8, log2 of on-chip memory depth in 16-bit words (256 words by default).
- WAIT_STATES, 2, number of wait cycles inserted before the memory access; legal range 0..15.
- IO_ADDR, 16'hFFFF, address of the memory-mapped I/O word (switches on read, hex display on write).

Ports:
- Clk  input  1  system clock, all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  1  request strobe; CPU holds it high until it sees Ready.
- WE  input  1  1 = write, 0 = read; sampled with Req.
- Addr  input  16  word address; sampled with Req.
- Wdata  input  16  write data; sampled with Req.
- Switches  input  16  external switch word, read at IO_ADDR.
- Rdata  output  16  registered read data; valid while Ready=1, then held.
- Ready  output  1  one-cycle completion pulse for reads and writes.
- Hex_Out  output  16  registered hex-display word, written at IO_ADDR.
- Err  output  1  sticky out-of-range-access flag.

Behaviour:
- Reset values: Rdata=0, Ready=0, Hex_Out=0, Err=0, FSM=IDLE, wait counter=0. Memory array contents are not cleared.
- States:
  - IDLE:
    - Ready=0.
    - If Req=1, latch Addr, WE and Wdata, and load counter=WAIT_STATES.
    - Go to WAIT if WAIT_STATES>0, otherwise go to ACCESS.
  - WAIT:
    - Decrement the counter each cycle.
    - Leave for ACCESS in the cycle the counter reaches 1 (exactly WAIT_STATES cycles spent in WAIT).
  - ACCESS (one cycle):
    - Perform the access on the latched request.
    - Read: Rdata is registered at the end of this cycle.
    - Write: the write commits at the end of this cycle.
    - Go to DONE.
  - DONE (one cycle):
    - Ready=1.
    - Go to IDLE unconditionally.
- Latency:
  - Req sampled in IDLE at cycle 0 puts Ready high in cycle WAIT_STATES+2.
  - Example: with WAIT_STATES=2, Req at cycle 0 gives Ready at cycle 4.
- Handshake:
  - Req is only sampled in IDLE. Changes to Req, Addr, WE or Wdata in the other states are ignored.
  - The CPU must drop Req in the cycle after Ready, or that cycle's Req starts a new transaction (legal back-to-back operation).
- Address decode, using the latched address:
  - Addr==IO_ADDR:
    - Read returns Switches as sampled in ACCESS.
    - Write updates Hex_Out at the end of ACCESS.
  - Addr[15:ADDR_W]==0: on-chip memory, word index Addr[ADDR_W-1:0].
  - Otherwise (out of range):
    - Write is dropped.
    - Read returns 16'h0000.
    - Err is set at the end of ACCESS.
    - Ready still pulses.
- Err is sticky and is cleared only by Reset.
- Rdata:
  - Changes only on a completed read.
  - Writes and I/O writes leave Rdata unchanged.
- Hex_Out changes only on a write to IO_ADDR.
- Reset mid-operation:
  - Reset in IDLE or WAIT: the FSM returns to IDLE, no write commits, and Ready stays 0.
  - Reset in ACCESS: it overrides the write enable, so no commit occurs.
  - Reset in DONE: Ready is forced to 0 in the following cycle.
  - Reset has priority over every other event.
- The wait counter is 4 bits wide. WAIT_STATES values outside 0..15 are a compile-time error (static assertion).

Decomposition:
- Package mem_resp_pkg:
  - state_t enum {IDLE, WAIT, ACCESS, DONE}.
  - Constant IO_ADDR_DEFAULT = 16'hFFFF.
  - Constant OOR_RDATA = 16'h0000.
- Sub-module ram_sp: single-port synchronous RAM.
  - Depth 2^ADDR_W, width 16.
  - Registered read output with 1-cycle latency; write-enable gated by Reset.
  - mem_responder presents the address in the cycle before ACCESS so the read data is available for the ACCESS-cycle capture.

Test Plan:
- Write then read, WAIT_STATES=2: Req/WE=1, Addr=16'h0012, Wdata=16'hBEEF; then read Addr=16'h0012 -> Ready exactly at cycle 4 of each transaction, Rdata=16'hBEEF, Err=0.
- I/O: Switches=16'h1234; read 16'hFFFF -> Rdata=16'h1234. Write 16'hFFFF with Wdata=16'h00A5 -> Hex_Out=16'h00A5 from the cycle after ACCESS, and Rdata unchanged (16'h1234).
- Out of range: write 16'h5A5A to 16'h0100 (ADDR_W=8), then read 16'h0100 -> Ready pulses both times, Rdata=16'h0000, Err=1 and stays 1; a subsequent read of 16'h0000 returns its stored value.
- Reset mid-WAIT: start a write of 16'hCAFE to 16'h0003 (word previously 16'h1111) and assert Reset in the first WAIT cycle -> Ready never pulses; a later read of 16'h0003 returns 16'h1111.
- Back-to-back, WAIT_STATES=0: hold Req=1 across two reads of 16'h0001 (16'hAAAA) and 16'h0002 (16'h5555) -> Ready at cycles 2 and 5, Rdata=16'hAAAA then 16'h5555.
- Request ignored while busy: change Addr to 16'h0002 during WAIT of a read of 16'h0001 -> Rdata returns word 1 (16'hAAAA).
